// File: rtl/util_pkg.sv
// Shared sizing helpers for reporting byte quantities in binary units.
// Each unit step is a factor of 1024, so moving up one unit is a 10-bit shift.
package util;

   typedef enum logic [2:0] {
      UNIT_B,
      UNIT_KIB,
      UNIT_MIB,
      UNIT_GIB,
      UNIT_TIB
   } byte_unit_t;

   localparam int UNIT_SHIFT = 10;

   localparam byte_unit_t UNIT_MAX = UNIT_TIB;

endpackage

// File: rtl/byte_size_scaler.sv
// Normalises a raw byte count into a mantissa plus binary unit (B..TiB).
// The count is divided by 1024 one step per cycle. Scaling stops when the
// mantissa drops below 1024 or when the unit reaches TiB. A sticky bit
// records whether any nonzero low bits were shifted away, which tells the
// consumer whether the mantissa is exact or truncated.
// Only one conversion is in flight at a time. A new count is taken in IDLE,
// the shifting happens in BUSY, and the result is held in DONE until the
// consumer accepts it.
module byte_size_scaler
   import util::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [CNT_W-1:0] count_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] mant_o,
   output logic [2:0]       unit_o,
   output logic             exact_o
);

   // At least one bit above the 10-bit unit field is needed, otherwise no
   // count could ever reach 1024 and the scaler would be meaningless.
   if (CNT_W < 11) begin : g_bad_width
      $error("byte_size_scaler: CNT_W must be at least 11");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] mant_q, mant_d;
   byte_unit_t       unit_q, unit_d;
   logic             sticky_q, sticky_d;

   logic             needShift;
   logic             lowBitsSet;

   // A further shift is needed while any bit at or above bit 10 is set, but
   // never past TiB; at TiB the mantissa is allowed to stay large.
   assign needShift  = (|mant_q[CNT_W-1:UNIT_SHIFT]) && (unit_q < UNIT_MAX);
   assign lowBitsSet = (mant_q[UNIT_SHIFT-1:0] != '0);

   // Next-state and datapath updates for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      unit_d   = unit_q;
      sticky_d = sticky_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               mant_d   = count_i;
               unit_d   = UNIT_B;
               sticky_d = 1'b0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (needShift) begin
               sticky_d = sticky_q | lowBitsSet;
               mant_d   = mant_q >> UNIT_SHIFT;
               unit_d   = byte_unit_t'(unit_q + 3'd1);
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         mant_q   <= '0;
         unit_q   <= UNIT_B;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         unit_q   <= unit_d;
         sticky_q <= sticky_d;
      end
   end

   // The result is only presented in DONE. At any other time the outputs
   // read as a neutral zero-byte exact result, so the consumer never sees
   // a partially scaled value.
   always_comb begin
      ready_o = (state_q == ST_IDLE);
      valid_o = (state_q == ST_DONE);
      mant_o  = '0;
      unit_o  = 3'd0;
      exact_o = 1'b1;
      if (state_q == ST_DONE) begin
         mant_o  = mant_q;
         unit_o  = unit_q;
         exact_o = ~sticky_q;
      end
   end

endmodule

// File: tb/tb_byte_size_scaler.sv
// Directed bench for byte_size_scaler. It uses hand-computed vectors,
// output stalls, a valid pulse while the block is busy, and an asynchronous
// reset in the middle of a conversion. A short random section then checks
// each result against an msb-position model of the minimal unit.
module tb_byte_size_scaler;

   logic        clk_i;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] count_i;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] mant_o;
   logic [2:0]  unit_o;
   logic        exact_o;

   int checkCount;
   int errorCount;

   byte_size_scaler #(.CNT_W(64)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .count_i (count_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .mant_o  (mant_o),
      .unit_o  (unit_o),
      .exact_o (exact_o)
   );

   // 100 MHz free-running clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one conversion. It waits for ready_o, performs the accept handshake,
   // and can optionally pulse valid_i with a different count during the first
   // BUSY cycle. It then measures the latency, checks the result, holds
   // ready_i low for holdCycles while checking stability, and finally
   // consumes the result.
   task automatic applyStimulus(input logic [63:0] count, input logic [63:0] expMant,
                                input logic [2:0] expUnit, input logic expExact,
                                input int holdCycles, input bit pulseBusy);
      int n;
      int wait_n;
      wait_n = 0;
      while (!ready_o && wait_n < 20) begin
         @(posedge clk_i); #1;
         wait_n++;
      end
      checkOutput("ready_before_accept", {63'd0, ready_o}, 64'd1);
      valid_i = 1'b1;
      count_i = count;
      @(posedge clk_i); #1;
      if (pulseBusy) begin
         valid_i = 1'b1;
         count_i = ~count;
      end else begin
         valid_i = 1'b0;
         count_i = 64'hDEAD_BEEF_0000_0000;
      end
      n = 0;
      while (!valid_o && n < 20) begin
         @(posedge clk_i); #1;
         valid_i = 1'b0;
         n++;
      end
      valid_i = 1'b0;
      checkOutput("latency", 64'(n + 1), 64'(expUnit) + 64'd2);
      checkOutput("mant", mant_o, expMant);
      checkOutput("unit", {61'd0, unit_o}, {61'd0, expUnit});
      checkOutput("exact", {63'd0, exact_o}, {63'd0, expExact});
      checkOutput("ready_in_done", {63'd0, ready_o}, 64'd0);
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk_i); #1;
         checkOutput("hold_valid", {63'd0, valid_o}, 64'd1);
         checkOutput("hold_ready", {63'd0, ready_o}, 64'd0);
         checkOutput("hold_mant", mant_o, expMant);
         checkOutput("hold_unit", {61'd0, unit_o}, {61'd0, expUnit});
         checkOutput("hold_exact", {63'd0, exact_o}, {63'd0, expExact});
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      checkOutput("ready_after_consume", {63'd0, ready_o}, 64'd1);
      checkOutput("valid_after_consume", {63'd0, valid_o}, 64'd0);
   endtask

   // Independent reference: the unit is chosen from the msb position, not by
   // iterating shifts.
   task automatic modelScale(input logic [63:0] count, output logic [63:0] m,
                             output logic [2:0] u, output logic e);
      int msb;
      int uu;
      logic [63:0] lowMask;
      msb = -1;
      for (int b = 0; b < 64; b++) begin
         if (count[b]) msb = b;
      end
      uu = (msb < 10) ? 0 : msb / 10;
      if (uu > 4) uu = 4;
      u = 3'(uu);
      m = count >> (10 * uu);
      lowMask = (uu == 0) ? 64'd0 : ((64'd1 << (10 * uu)) - 64'd1);
      e = ((count & lowMask) == 64'd0);
   endtask

   initial begin
      logic [63:0] rc;
      logic [63:0] rm;
      logic [2:0]  ru;
      logic        re;
      int          riseCount;

      checkCount = 0;
      errorCount = 0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      count_i = 64'd0;
      rst_i   = 1'b1;
      #12;
      checkOutput("rst_ready", {63'd0, ready_o}, 64'd1);
      checkOutput("rst_valid", {63'd0, valid_o}, 64'd0);
      checkOutput("rst_mant", mant_o, 64'd0);
      checkOutput("rst_unit", {61'd0, unit_o}, 64'd0);
      checkOutput("rst_exact", {63'd0, exact_o}, 64'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      applyStimulus(64'd0,                         64'd0,        3'd0, 1'b1, 0, 1'b0);
      applyStimulus(64'd1023,                      64'd1023,     3'd0, 1'b1, 0, 1'b0);
      applyStimulus(64'd1024,                      64'd1,        3'd1, 1'b1, 0, 1'b0);
      applyStimulus(64'd1025,                      64'd1,        3'd1, 1'b0, 0, 1'b0);
      applyStimulus(64'd3 << 30,                   64'd3,        3'd3, 1'b1, 0, 1'b0);
      applyStimulus((64'd1 << 50) + 64'd5,         64'd1024,     3'd4, 1'b0, 0, 1'b1);
      applyStimulus(64'd1048575,                   64'd1023,     3'd1, 1'b0, 0, 1'b0);
      applyStimulus((64'd1 << 20) + (64'd1 << 10), 64'd1,        3'd2, 1'b0, 0, 1'b0);
      applyStimulus(64'd1 << 40,                   64'd1,        3'd4, 1'b1, 0, 1'b0);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF,       64'hFF_FFFF,  3'd4, 1'b0, 0, 1'b0);
      applyStimulus(64'd5 << 20,                   64'd5,        3'd2, 1'b1, 10, 1'b0);

      // Reset asserted mid-BUSY must abort the conversion silently.
      valid_i = 1'b1;
      count_i = 64'd1 << 35;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      @(posedge clk_i); #3;
      rst_i = 1'b1;
      #1;
      checkOutput("async_rst_ready", {63'd0, ready_o}, 64'd1);
      checkOutput("async_rst_valid", {63'd0, valid_o}, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      riseCount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) riseCount++;
      end
      checkOutput("aborted_no_result", 64'(riseCount), 64'd0);
      checkOutput("ready_after_abort", {63'd0, ready_o}, 64'd1);
      applyStimulus(64'd2048, 64'd2, 3'd1, 1'b1, 0, 1'b0);

      // Random counts spread over all magnitudes with random stalls.
      for (int i = 0; i < 20; i++) begin
         rc = {$urandom, $urandom};
         rc = rc >> $urandom_range(63, 0);
         modelScale(rc, rm, ru, re);
         applyStimulus(rc, rm, ru, re, int'($urandom_range(3, 0)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
